uart_tx_queue: RTL

Byte transmit queue between the CPU-side UART register write path and the `uart_send` serializer. It absorbs bursts of bus writes into a circular FIFO and drains them one byte at a time through an enable-pulse / busy handshake with the serializer. It reports fill level, full and overflow status to the bus, plus an optional drain-complete interrupt.

---
 rtl/uart_tx_queue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Byte transmit queue: circular FIFO feeding the uart_send serializer via a tx_en/tx_busy handshake.
// Optional drain-complete interrupt is built when UART_TXQ_IRQ_EN is defined; otherwise int_tx is tied low.
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     clr_ovf,
  input  logic                     tx_busy,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic                     int_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT);

  // Handshake: tx_en is a single-cycle launch pulse, only issued from LAUNCH, which is
  // reached solely from IDLE; IDLE is only re-entered once tx_busy is low or the busy-rise
  // wait has timed out, so tx_en is never raised while the serializer reports busy.
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   tmo_cnt;
  logic            push;
  logic            pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign push  = wr_en && !full;

  always_comb begin
    state_next = state;
    tx_en      = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_en      = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timeout counter only advances while waiting for the serializer to acknowledge.
  always_ff @(posedge clk) begin
    if (rst || state == LAUNCH) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_BUSY && !tx_busy) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_data <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped push outranks a same-cycle clear so no overflow is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

`ifdef UART_TXQ_IRQ_EN
  logic drain_done;

  assign drain_done = (state == WAIT_DONE || state == WAIT_BUSY) && state_next == IDLE &&
                      empty && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_tx <= 1'b0;
    end else if (push) begin
      int_tx <= 1'b0;
    end else if (drain_done) begin
      int_tx <= 1'b1;
    end
  end
`else
  assign int_tx = 1'b0;
`endif

endmodule
